iic_slavemod: RTL and testbench

IIC_SLAVEMOD -- requirements
Module: iic_slavemod

---
 rtl/iic_slavemod.sv | 201 ++++++++++++++++++++
 tb/tb_iic_slavemod.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/iic_slavemod.sv
// IIC slave at a 7-bit address, exposing a 16 x 8 register file through an
// auto-incrementing register pointer; the host side reads it with 1-cycle latency.
module iic_slavemod #(
    parameter logic [6:0] DEV_ADDR   = 7'h51,
    parameter int         CLKDIV_MIN = 4
) (
    input  logic       CLOCK,
    input  logic       RESET,
    input  logic       SCL,
    inout  wire        SDA,
    input  logic [3:0] iRdAddr,
    output logic [7:0] oRdData,
    output logic       oWrPulse,
    output logic [3:0] oWrAddr,
    output logic [7:0] oWrData,
    output logic       oBusy
);
    // An SCL phase must outlast the 3-cycle input latency plus one drive cycle.
    if (CLKDIV_MIN < 4) begin : g_clkdiv_check
        $error("iic_slavemod: CLKDIV_MIN below the sampling margin");
    end

    typedef enum logic [3:0] {
        IDLE, DADDR, DACK, RADDR, RACK, WDATA, WACK, RDATA, MACK
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] scl_q, scl_d, sda_q, sda_d;
    logic [3:0] bit_cnt_q, bit_cnt_d, ptr_q, ptr_d;
    logic [6:0] shift_q, shift_d, tx_q, tx_d;
    logic       sda_oe_q, sda_oe_d, busy_q, busy_d, wr_pulse_q, wr_pulse_d;
    logic [3:0] wr_addr_q, wr_addr_d;
    logic [7:0] wr_data_q, wr_data_d, rd_data_q, rd_data_d;
    logic [7:0] regs_q [16];
    logic [7:0] regs_d [16];

    logic       scl_rise, scl_fall, start_det, stop_det, byte_done, ack_end;
    logic [7:0] rx_byte, cur_byte;

    // Index [1] is the synchronized level, [2] the delayed copy for edge detection.
    assign scl_rise  = scl_q[1] & ~scl_q[2];
    assign scl_fall  = ~scl_q[1] & scl_q[2];
    assign start_det = scl_q[1] & scl_q[2] & ~sda_q[1] & sda_q[2];
    assign stop_det  = scl_q[1] & scl_q[2] & sda_q[1] & ~sda_q[2];
    assign rx_byte   = {shift_q, sda_q[1]};
    assign byte_done = scl_rise && (bit_cnt_q == 4'd7);
    assign ack_end   = scl_fall && (bit_cnt_q == 4'd9);
    assign cur_byte  = regs_q[ptr_q];

    assign SDA      = sda_oe_q ? 1'b0 : 1'bz;
    assign oRdData  = rd_data_q;
    assign oWrPulse = wr_pulse_q;
    assign oWrAddr  = wr_addr_q;
    assign oWrData  = wr_data_q;
    assign oBusy    = busy_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q    <= IDLE;
            scl_q      <= '1;
            sda_q      <= '1;
            bit_cnt_q  <= '0;
            ptr_q      <= '0;
            shift_q    <= '0;
            tx_q       <= '0;
            sda_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            wr_pulse_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            rd_data_q  <= '0;
            // NOTE: the register file is reset explicitly because the host may read it before any bus write.
            for (int i = 0; i < 16; i++) regs_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            scl_q      <= scl_d;
            sda_q      <= sda_d;
            bit_cnt_q  <= bit_cnt_d;
            ptr_q      <= ptr_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            sda_oe_q   <= sda_oe_d;
            busy_q     <= busy_d;
            wr_pulse_q <= wr_pulse_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            rd_data_q  <= rd_data_d;
            regs_q     <= regs_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (stop_det) begin
            state_d = IDLE;
        end else if (start_det) begin
            state_d = DADDR;
        end else begin
            case (state_q)
                DADDR:   if (byte_done) state_d = (rx_byte[7:1] == DEV_ADDR) ? DACK : IDLE;
                DACK:    if (ack_end) state_d = shift_q[0] ? RDATA : RADDR;
                RADDR:   if (byte_done) state_d = RACK;
                RACK:    if (ack_end) state_d = WDATA;
                WDATA:   if (byte_done) state_d = WACK;
                WACK:    if (ack_end) state_d = WDATA;
                RDATA:   if (scl_fall && bit_cnt_q == 4'd8) state_d = MACK;
                MACK: begin
                    if (scl_rise && sda_q[1]) state_d = IDLE;
                    else if (ack_end)         state_d = RDATA;
                end
                default: state_d = state_q;
            endcase
        end
    end

    // NOTE: every variable gets a default first so no path through this block can infer a latch.
    always_comb begin
        scl_d      = {scl_q[1:0], SCL};
        sda_d      = {sda_q[1:0], SDA};
        bit_cnt_d  = bit_cnt_q;
        ptr_d      = ptr_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        sda_oe_d   = sda_oe_q;
        busy_d     = busy_q;
        wr_pulse_d = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        rd_data_d  = regs_q[iRdAddr];
        regs_d     = regs_q;
        if (stop_det || start_det) begin
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
        end else begin
            case (state_q)
                DADDR, RADDR, WDATA: begin
                    if (scl_rise) begin
                        shift_d   = rx_byte[6:0];
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                    if (byte_done) begin
                        if (state_q == DADDR) begin
                            if (rx_byte[7:1] == DEV_ADDR) busy_d = 1'b1;
                            else                          bit_cnt_d = '0;
                        end else if (state_q == RADDR) begin
                            ptr_d = rx_byte[3:0];
                        end else begin
                            wr_pulse_d     = 1'b1;
                            wr_addr_d      = ptr_q;
                            wr_data_d      = rx_byte;
                            regs_d[ptr_q]  = rx_byte;
                            ptr_d          = ptr_q + 4'd1;
                        end
                    end
                end
                DACK, RACK, WACK: begin
                    if (scl_fall && bit_cnt_q == 4'd8) sda_oe_d = 1'b1;
                    if (scl_rise) bit_cnt_d = 4'd9;
                    if (ack_end) begin
                        bit_cnt_d = '0;
                        sda_oe_d  = 1'b0;
                        if (state_q == DACK && shift_q[0]) begin
                            tx_d     = cur_byte[6:0];
                            sda_oe_d = ~cur_byte[7];
                        end
                    end
                end
                RDATA: begin
                    if (scl_rise) bit_cnt_d = bit_cnt_q + 4'd1;
                    if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            sda_oe_d = 1'b0;
                            ptr_d    = ptr_q + 4'd1;
                        end else begin
                            sda_oe_d = ~tx_q[6];
                            tx_d     = {tx_q[5:0], 1'b0};
                        end
                    end
                end
                MACK: begin
                    if (scl_rise) begin
                        if (sda_q[1]) begin
                            bit_cnt_d = '0;
                            busy_d    = 1'b0;
                        end else begin
                            bit_cnt_d = 4'd9;
                        end
                    end
                    if (ack_end) begin
                        bit_cnt_d = '0;
                        tx_d      = cur_byte[6:0];
                        sda_oe_d  = ~cur_byte[7];
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_iic_slavemod.sv
// Directed bench for iic_slavemod: a bit-banged IIC master with hand-computed
// expected values for writes, random reads, NACK, pointer wrap, abort and reset.
module tb_iic_slavemod;
    localparam int QTR  = 4;
    localparam int HALF = 8;

    logic       CLOCK    = 1'b0;
    logic       RESET    = 1'b1;
    logic       m_scl    = 1'b1;
    logic       m_sda_oe = 1'b0;
    logic [3:0] iRdAddr  = 4'h0;
    wire        sda_w;
    wire  [7:0] oRdData;
    wire        oWrPulse;
    wire  [3:0] oWrAddr;
    wire  [7:0] oWrData;
    wire        oBusy;

    int         checks = 0;
    int         failures = 0;
    int         pulse_cnt = 0;
    int         busy_cycles = 0;
    logic [3:0] pw_addr [16];
    logic [7:0] pw_data [16];

    pullup (sda_w);
    assign sda_w = m_sda_oe ? 1'b0 : 1'bz;

    iic_slavemod #(.DEV_ADDR(7'h51), .CLKDIV_MIN(4)) dut (
        .CLOCK   (CLOCK),
        .RESET   (RESET),
        .SCL     (m_scl),
        .SDA     (sda_w),
        .iRdAddr (iRdAddr),
        .oRdData (oRdData),
        .oWrPulse(oWrPulse),
        .oWrAddr (oWrAddr),
        .oWrData (oWrData),
        .oBusy   (oBusy)
    );

    always #5 CLOCK = ~CLOCK;

    always @(negedge CLOCK) begin
        if (oBusy) busy_cycles++;
        if (oWrPulse) begin
            if (pulse_cnt < 16) begin
                pw_addr[pulse_cnt] = oWrAddr;
                pw_data[pulse_cnt] = oWrData;
            end
            pulse_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge CLOCK);
    endtask

    task automatic i2c_start();
        m_sda_oe = 1'b1;
        wait_clk(HALF);
        m_scl = 1'b0;
        wait_clk(QTR);
    endtask

    task automatic i2c_rstart();
        m_sda_oe = 1'b0;
        wait_clk(QTR);
        m_scl = 1'b1;
        wait_clk(HALF);
        i2c_start();
    endtask

    task automatic i2c_stop();
        m_sda_oe = 1'b1;
        wait_clk(QTR);
        m_scl = 1'b1;
        wait_clk(HALF);
        m_sda_oe = 1'b0;
        wait_clk(HALF);
    endtask

    task automatic send_bit(input logic b);
        m_sda_oe = ~b;
        wait_clk(QTR);
        m_scl = 1'b1;
        wait_clk(HALF);
        m_scl = 1'b0;
        wait_clk(QTR);
    endtask

    task automatic recv_bit(output logic b);
        m_sda_oe = 1'b0;
        wait_clk(QTR);
        m_scl = 1'b1;
        wait_clk(QTR);
        b = sda_w;
        wait_clk(QTR);
        m_scl = 1'b0;
        wait_clk(QTR);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        recv_bit(ack);
    endtask

    task automatic read_byte(output logic [7:0] d, input logic nack);
        logic b;
        d = '0;
        for (int i = 7; i >= 0; i--) begin
            recv_bit(b);
            d[i] = b;
        end
        send_bit(nack);
    endtask

    initial begin
        logic       ack;
        logic [7:0] rd;
        int         p0;
        int         b0;

        wait_clk(3);
        RESET = 1'b0;
        wait_clk(2);
        check("rst_rddata", oRdData, 8'h00);
        check("rst_wrpulse", oWrPulse, 1'b0);
        check("rst_wraddr", oWrAddr, 4'h0);
        check("rst_wrdata", oWrData, 8'h00);
        check("rst_busy", oBusy, 1'b0);
        check("rst_sda", sda_w, 1'b1);

        // Write 45, 59 starting at register 2
        i2c_start();
        write_byte(8'hA2, ack); check("wr_ack_dev", ack, 1'b0);
        write_byte(8'h02, ack); check("wr_ack_ptr", ack, 1'b0);
        check("wr_busy", oBusy, 1'b1);
        write_byte(8'h45, ack); check("wr_ack_d0", ack, 1'b0);
        write_byte(8'h59, ack); check("wr_ack_d1", ack, 1'b0);
        i2c_stop();
        wait_clk(4);
        check("wr_busy_after_stop", oBusy, 1'b0);
        check("wr_pulse_cnt", pulse_cnt, 2);
        check("wr_pulse0_addr", pw_addr[0], 4'h2);
        check("wr_pulse0_data", pw_data[0], 8'h45);
        check("wr_pulse1_addr", pw_addr[1], 4'h3);
        check("wr_pulse1_data", pw_data[1], 8'h59);
        iRdAddr = 4'h3; wait_clk(2); check("host_rd_3", oRdData, 8'h59);
        iRdAddr = 4'h2; wait_clk(2); check("host_rd_2", oRdData, 8'h45);

        // Random read of registers 2 and 3 through a repeated START
        p0 = pulse_cnt;
        i2c_start();
        write_byte(8'hA2, ack); check("rr_ack_dev", ack, 1'b0);
        write_byte(8'h02, ack); check("rr_ack_ptr", ack, 1'b0);
        i2c_rstart();
        write_byte(8'hA3, ack); check("rr_ack_rd", ack, 1'b0);
        check("rr_busy", oBusy, 1'b1);
        read_byte(rd, 1'b0); check("rr_byte0", rd, 8'h45);
        read_byte(rd, 1'b1); check("rr_byte1", rd, 8'h59);
        wait_clk(QTR);
        check("rr_sda_released", sda_w, 1'b1);
        check("rr_busy_after_nack", oBusy, 1'b0);
        i2c_stop();
        check("rr_no_pulse", pulse_cnt - p0, 0);

        // Address mismatch
        p0 = pulse_cnt;
        b0 = busy_cycles;
        i2c_start();
        write_byte(8'hA0, ack); check("na_nack", ack, 1'b1);
        i2c_stop();
        check("na_busy_never", busy_cycles - b0, 0);
        check("na_no_pulse", pulse_cnt - p0, 0);

        // Pointer wrap F -> 0
        i2c_start();
        write_byte(8'hA2, ack); check("wrap_ack_dev", ack, 1'b0);
        write_byte(8'h0F, ack);
        write_byte(8'h11, ack); check("wrap_ack_d0", ack, 1'b0);
        write_byte(8'h22, ack); check("wrap_ack_d1", ack, 1'b0);
        i2c_stop();
        check("wrap_pulse_cnt", pulse_cnt, 4);
        check("wrap_pulse2_addr", pw_addr[2], 4'hF);
        check("wrap_pulse2_data", pw_data[2], 8'h11);
        check("wrap_pulse3_addr", pw_addr[3], 4'h0);
        check("wrap_pulse3_data", pw_data[3], 8'h22);
        iRdAddr = 4'hF; wait_clk(2); check("wrap_rd_f", oRdData, 8'h11);
        iRdAddr = 4'h0; wait_clk(2); check("wrap_rd_0", oRdData, 8'h22);

        // STOP after 4 bits of a data byte
        p0 = pulse_cnt;
        i2c_start();
        write_byte(8'hA2, ack);
        write_byte(8'h05, ack);
        send_bit(1'b0); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        i2c_stop();
        wait_clk(4);
        check("abort_no_pulse", pulse_cnt - p0, 0);
        check("abort_busy", oBusy, 1'b0);
        i2c_start();
        write_byte(8'hA2, ack); check("abort_next_ack_dev", ack, 1'b0);
        write_byte(8'h05, ack); check("abort_next_ack_ptr", ack, 1'b0);
        i2c_stop();
        iRdAddr = 4'h5; wait_clk(2); check("abort_rd_5", oRdData, 8'h00);

        // RESET while the slave pulls SDA low for bit 7 of 8'h45
        i2c_start();
        write_byte(8'hA2, ack);
        write_byte(8'h02, ack);
        i2c_rstart();
        write_byte(8'hA3, ack); check("rst_rd_ack", ack, 1'b0);
        check("rst_drive_low", sda_w, 1'b0);
        RESET = 1'b1;
        wait_clk(1);
        check("rst_sda_release", sda_w, 1'b1);
        wait_clk(1);
        RESET = 1'b0;
        iRdAddr = 4'h2; wait_clk(2); check("rst_reg2_clear", oRdData, 8'h00);
        iRdAddr = 4'h3; wait_clk(2); check("rst_reg3_clear", oRdData, 8'h00);
        check("rst_busy_clear", oBusy, 1'b0);
        i2c_stop();
        i2c_start();
        write_byte(8'hA2, ack); check("rst_next_ack", ack, 1'b0);
        i2c_stop();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
